xor_parity_accumulator: RTL



---
 rtl/xor_parity_accumulator_pkg.sv | 22 ++
 rtl/xor_parity_accumulator_if.sv | 37 +++
 rtl/xor_parity_accumulator_bit_counter.sv | 42 ++++
 rtl/xor_parity_accumulator.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/xor_parity_accumulator_pkg.sv
// Shared types and helpers for the serial XOR parity accumulator.
// Frame length depends on the PARITY_CHECK_EN macro (adds one received parity bit).
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int FRAME_LEN_MAX = 255;

  // Total accepted bits per frame, including the received parity bit when checking.
  function automatic int frame_bits(input int frame_len);
`ifdef PARITY_CHECK_EN
    return frame_len + 1;
`else
    return frame_len;
`endif
  endfunction

endpackage

// File: rtl/xor_parity_accumulator_if.sv
// Input/output valid-ready handshakes of the parity accumulator.
// out_err exists only when PARITY_CHECK_EN is defined.
interface xor_parity_accumulator_if;
  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_ready;
  logic out_parity;
`ifdef PARITY_CHECK_EN
  logic out_err;
`endif

  modport master (
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
`ifdef PARITY_CHECK_EN
    input  out_err,
`endif
    input  out_parity
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
`ifdef PARITY_CHECK_EN
    output out_err,
`endif
    output out_parity
  );
endinterface

// File: rtl/xor_parity_accumulator_bit_counter.sv
// Saturating frame bit counter with clear; flags when the next increment completes the frame.
module parity_bit_counter #(
  parameter int FRAME_BITS = 8,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear wins, increment saturates at the frame length.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < CNT_FULL)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_TERM);

endmodule

// File: rtl/xor_parity_accumulator.sv
// Folds one accepted bit per cycle into a running XOR and presents the frame parity.
// With PARITY_CHECK_EN the last bit is a received parity bit compared into out_err.
module xor_parity_accumulator
  import parity_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_clr,
  xor_parity_accumulator_if.slave bus
);

  localparam int FRAME_BITS = frame_bits(FRAME_LEN);
  localparam int CNT_W      = $clog2(FRAME_LEN + 2);

  state_e state_d;
  state_e state_q;
  logic   acc_d;
  logic   acc_q;
  logic   out_valid_d;
  logic   out_valid_q;
  logic   out_parity_d;
  logic   out_parity_q;
`ifdef PARITY_CHECK_EN
  logic   out_err_d;
  logic   out_err_q;
`endif

  logic in_ready_s;
  logic accept_s;
  logic acc_base_s;
  logic frame_last_s;
  logic cnt_clr_s;
  logic cnt_inc_s;

  assign in_ready_s = (state_q == IDLE) || (state_q == ACCUM);
  assign accept_s   = bus.in_valid && in_ready_s;
  // A fresh frame starts from zero regardless of what acc currently holds.
  assign acc_base_s = (state_q == IDLE) ? 1'b0 : acc_q;

  parity_bit_counter #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .last  (frame_last_s)
  );

  // Next-state, accumulator and output register updates.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
`ifdef PARITY_CHECK_EN
    out_err_d    = out_err_q;
`endif
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;

    if (sync_clr) begin
      state_d      = IDLE;
      acc_d        = 1'b0;
      out_valid_d  = 1'b0;
      out_parity_d = 1'b0;
`ifdef PARITY_CHECK_EN
      out_err_d    = 1'b0;
`endif
      cnt_clr_s    = 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept_s) begin
            cnt_inc_s = 1'b1;
            if (frame_last_s) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
              // Received parity bit: compared, never folded into acc.
              acc_d        = acc_base_s;
              out_parity_d = acc_base_s;
              out_err_d    = acc_base_s ^ bus.in_bit;
`else
              acc_d        = acc_base_s ^ bus.in_bit;
              out_parity_d = acc_base_s ^ bus.in_bit;
`endif
            end else begin
              state_d = ACCUM;
              acc_d   = acc_base_s ^ bus.in_bit;
            end
          end else begin
            state_d = state_q;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d     = IDLE;
            acc_d       = 1'b0;
            out_valid_d = 1'b0;
            cnt_clr_s   = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = 1'b0;
          out_valid_d = 1'b0;
          cnt_clr_s   = 1'b1;
        end
      endcase
    end
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      out_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
`ifdef PARITY_CHECK_EN
      out_err_q    <= out_err_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_parity = out_parity_q;
`ifdef PARITY_CHECK_EN
  assign bus.out_err    = out_err_q;
`endif

endmodule
